mdio_master: RTL and testbench

- IEEE 802.3 Clause 22 MDIO management master that configures and queries the Ethernet PHY over MDC/MDIO.
- Accepts single read/write commands through a valid/ready interface and serialises one 64-bit management frame per command.
- Its mdc/mdio_out/mdio_oen/mdio_in connect to the board MDIO pad exactly as the TSE MDIO connection does: pad = mdio_oen ? Z : mdio_out.
- Used for PHY bring-up (reset, autoneg, RGMII delay) and for link/speed polling.

---
 rtl/mdio_master.sv | 204 ++++++++++++++++++++
 tb/tb_mdio_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// Clause 22 MDIO master: one 64-bit frame per command (128*CLK_DIV cycles, rsp_valid the cycle after); cmd_ready only in IDLE, no queueing.
// Optional MDIO_PRE_SUPPRESS_EN adds cmd_nopre, which skips the 32-bit preamble (32-bit frame).
module mdio_master #(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
`ifdef MDIO_PRE_SUPPRESS_EN
    input  logic        cmd_nopre,
`endif
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [1:0]  ta;
        logic [15:0] data;
    } frame_t;

    localparam logic [7:0] PHASE_LOAD = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        mdc_q, mdc_d;
    logic [63:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic        write_q, write_d;
    logic        ta_err_q, ta_err_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        nopre;
    logic        accept;
    logic        in_frame;
    logic        phase_end;
    logic        bit_end;
    logic        last_bit;
    logic        released;
    frame_t      frame;

`ifdef MDIO_PRE_SUPPRESS_EN
    assign nopre = cmd_nopre;
`else
    assign nopre = 1'b0;
`endif

    assign in_frame  = (state_q == S_PRE) || (state_q == S_HDR) ||
                       (state_q == S_TA)  || (state_q == S_DATA);
    assign accept    = cmd_valid && (state_q == S_IDLE);
    assign phase_end = (phase_q == 8'd0);
    assign bit_end   = in_frame && phase_end && mdc_q;
    // Read frames hand the pad to the PHY from the first turnaround bit onward.
    assign released  = !write_q && ((state_q == S_TA) || (state_q == S_DATA));

    always_comb begin
        frame.st   = 2'b01;
        frame.op   = cmd_write ? 2'b01 : 2'b10;
        frame.phy  = cmd_phy;
        frame.rg   = cmd_reg;
        frame.ta   = cmd_write ? 2'b10 : 2'b11;
        frame.data = cmd_write ? cmd_wdata : 16'hFFFF;
    end

    always_comb begin
        last_bit = 1'b0;
        case (state_q)
            S_PRE:   last_bit = (bit_cnt_q == 6'd31);
            S_HDR:   last_bit = (bit_cnt_q == 6'd13);
            S_TA:    last_bit = (bit_cnt_q == 6'd1);
            S_DATA:  last_bit = (bit_cnt_q == 6'd15);
            default: last_bit = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)              state_d = nopre ? S_HDR : S_PRE;
            S_PRE:  if (bit_end && last_bit) state_d = S_HDR;
            S_HDR:  if (bit_end && last_bit) state_d = S_TA;
            S_TA:   if (bit_end && last_bit) state_d = S_DATA;
            S_DATA: if (bit_end && last_bit) state_d = S_DONE;
            S_DONE:                          state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = in_frame;
        rsp_valid = (state_q == S_DONE);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        mdc       = mdc_q;
        mdio_oen  = !in_frame || released;
        mdio_out  = (in_frame && !released) ? tx_q[63] : 1'b1;
    end

    // Datapath next-state: MDC phase timing, frame shift-out, read shift-in
    always_comb begin
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        mdc_d     = mdc_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        write_d   = write_q;
        ta_err_d  = ta_err_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        if (accept) begin
            phase_d   = PHASE_LOAD;
            bit_cnt_d = 6'd0;
            mdc_d     = 1'b0;
            write_d   = cmd_write;
            tx_d      = nopre ? {frame, 32'hFFFF_FFFF} : {32'hFFFF_FFFF, frame};
        end else if (in_frame) begin
            if (!phase_end) begin
                phase_d = phase_q - 8'd1;
            end else begin
                phase_d = PHASE_LOAD;
                mdc_d   = !mdc_q;
                if (!mdc_q) begin
                    // Rising MDC: the PHY's bit has been stable for a full low phase.
                    if (!write_q && (state_q == S_TA) && (bit_cnt_q == 6'd1)) begin
                        ta_err_d = mdio_in;
                    end
                    if (!write_q && (state_q == S_DATA)) begin
                        rx_d = {rx_q[14:0], mdio_in};
                    end
                end else begin
                    tx_d      = {tx_q[62:0], 1'b1};
                    bit_cnt_d = last_bit ? 6'd0 : bit_cnt_q + 6'd1;
                    // Publish read results so they are visible alongside rsp_valid.
                    if ((state_q == S_DATA) && last_bit && !write_q) begin
                        rdata_d = rx_q;
                        err_d   = ta_err_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= 8'd0;
            bit_cnt_q <= 6'd0;
            mdc_q     <= 1'b0;
            tx_q      <= '1;
            rx_q      <= 16'd0;
            write_q   <= 1'b0;
            ta_err_q  <= 1'b0;
            rdata_q   <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            mdc_q     <= mdc_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            write_q   <= write_d;
            ta_err_q  <= ta_err_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master with CLK_DIV=4: vector table plus back-to-back, abort and preamble-suppress sequences.
module tb_mdio_master;
    localparam int CLK_DIV = 4;
    localparam int BUDGET  = 3000;

    typedef struct {
        bit          wr;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wd;
        bit          phy_on;
        logic [15:0] phy_dat;
        logic [13:0] exp_hdr;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_phy = 5'd0;
    logic [4:0]  cmd_reg = 5'd0;
    logic [15:0] cmd_wdata = 16'd0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        mdc;
    logic        mdio_in = 1'b1;
    logic        mdio_out;
    logic        mdio_oen;
`ifdef MDIO_PRE_SUPPRESS_EN
    logic        cmd_nopre = 1'b0;
`endif
    bit          tb_nopre = 1'b0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mdio_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_phy   (cmd_phy),
        .cmd_reg   (cmd_reg),
        .cmd_wdata (cmd_wdata),
`ifdef MDIO_PRE_SUPPRESS_EN
        .cmd_nopre (cmd_nopre),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mdc       (mdc),
        .mdio_in   (mdio_in),
        .mdio_out  (mdio_out),
        .mdio_oen  (mdio_oen)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // PHY model: index is the bit position within a full 64-bit frame.
    function automatic logic phy_bit(input vec_t v, input int i);
        if (!v.phy_on) return 1'b1;
        if (i == 47) return 1'b0;
        if (i >= 48 && i <= 63) return v.phy_dat[63-i];
        return 1'b1;
    endfunction

    task automatic issue(input vec_t v, input bit nopre, input bit hold, input vec_t nxt);
        @(negedge clk);
        chk("ready_pre_accept", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_phy   = v.phy;
        cmd_reg   = v.rg;
        cmd_wdata = v.wd;
        tb_nopre  = nopre;
`ifdef MDIO_PRE_SUPPRESS_EN
        cmd_nopre = nopre;
`endif
        @(posedge clk);
        #1;
        if (hold) begin
            cmd_write = nxt.wr;
            cmd_phy   = nxt.phy;
            cmd_reg   = nxt.rg;
            cmd_wdata = nxt.wd;
        end else begin
            cmd_valid = 1'b0;
            cmd_write = ~v.wr;
            cmd_phy   = ~v.phy;
            cmd_reg   = ~v.rg;
            cmd_wdata = ~v.wd;
        end
    endtask

    task automatic capture(input vec_t v);
        int nbits_exp, pre, nb, busy_cyc, rv_cnt, rv_cyc, rdy_cnt, ones, bad_oen;
        logic prev_mdc, f_busy, f_mdc, f_oen, rv_err;
        logic cap_out[64];
        logic cap_oen[64];
        logic [13:0] hdr;
        logic [15:0] dat, rv_rdata;
        logic [1:0]  ta;
        bit finished;
        pre = tb_nopre ? 0 : 32;
        nbits_exp = pre + 32;
        nb = 0; busy_cyc = 0; rv_cnt = 0; rv_cyc = -1; rdy_cnt = 0; ones = 0; bad_oen = 0;
        prev_mdc = 1'b0; f_busy = 1'b0; f_mdc = 1'b1; f_oen = 1'b1;
        rv_err = 1'bx; rv_rdata = 'x; finished = 1'b0;
        hdr = '0; dat = '0; ta = '0;
        mdio_in = 1'b1;
        for (int i = 0; i < 64; i++) begin
            cap_out[i] = 1'bx;
            cap_oen[i] = 1'bx;
        end
        for (int cyc = 1; cyc <= BUDGET && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                f_busy = busy; f_mdc = mdc; f_oen = mdio_oen;
            end
            if (busy) busy_cyc++;
            if (cmd_ready && rv_cnt == 0) rdy_cnt++;
            if (mdc && !prev_mdc && nb < 64) begin
                cap_out[nb] = mdio_out;
                cap_oen[nb] = mdio_oen;
                nb++;
            end
            if (!mdc && prev_mdc) mdio_in = phy_bit(v, nb + 64 - nbits_exp);
            prev_mdc = mdc;
            if (rsp_valid) begin
                rv_cnt++;
                if (rv_cnt == 1) begin
                    rv_cyc = cyc; rv_rdata = rsp_rdata; rv_err = rsp_err;
                end
            end
            if (rv_cnt > 0 && cyc == rv_cyc + 1) finished = 1'b1;
        end
        chk("frame_completed", finished, 1);
        chk("first_cycle_busy", f_busy, 1);
        chk("first_cycle_mdc", f_mdc, 0);
        chk("first_cycle_oen", f_oen, 0);
        chk("bit_count", nb, nbits_exp);
        for (int i = 0; i < pre; i++) if (cap_out[i] === 1'b1) ones++;
        chk("preamble_ones", ones, pre);
        for (int i = 0; i < 14; i++) hdr[13-i] = cap_out[pre+i];
        chk("header_bits", hdr, v.exp_hdr);
        for (int i = 0; i < nb; i++)
            if (cap_oen[i] !== ((!v.wr && i >= pre + 14) ? 1'b1 : 1'b0)) bad_oen++;
        chk("oen_pattern_errors", bad_oen, 0);
        if (v.wr) begin
            ta = {cap_out[pre+14], cap_out[pre+15]};
            for (int i = 0; i < 16; i++) dat[15-i] = cap_out[pre+16+i];
            chk("write_ta", ta, 2'b10);
            chk("write_data", dat, v.wd);
        end
        chk("busy_cycles", busy_cyc, nbits_exp * 2 * CLK_DIV);
        chk("rsp_valid_cycle", rv_cyc, nbits_exp * 2 * CLK_DIV + 1);
        chk("rsp_valid_pulses", rv_cnt, 1);
        chk("ready_during_frame", rdy_cnt, 0);
        chk("rsp_rdata", rv_rdata, v.exp_rdata);
        chk("rsp_err", rv_err, v.exp_err);
        chk("idle_after_done", {cmd_ready, busy, mdc, mdio_oen, mdio_out}, 5'b10011);
    endtask

    initial begin
        vec_t vecs[5];
        vec_t v;
        int   rises;
        int   seen;
        logic prev;
        // wr, phy, reg, wdata, phy_on, phy_dat, exp_hdr (ST OP PHYAD REGAD), exp_rdata, exp_err
        vecs[0] = '{1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0000, 14'b01_01_00001_00000, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 5'h01, 5'h01, 16'h0000, 1'b1, 16'h796D, 14'b01_10_00001_00001, 16'h796D, 1'b0};
        vecs[2] = '{1'b0, 5'h1F, 5'h02, 16'h0000, 1'b0, 16'h0000, 14'b01_10_11111_00010, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b1, 5'h12, 5'h1B, 16'hA5C3, 1'b0, 16'h0000, 14'b01_01_10010_11011, 16'hFFFF, 1'b1};
        vecs[4] = '{1'b0, 5'h0A, 5'h15, 16'h0000, 1'b1, 16'h0001, 14'b01_10_01010_10101, 16'h0001, 1'b0};

        #1 reset_n = 1'b0;
        #1;
        chk("reset_outputs", {mdc, mdio_out, mdio_oen, cmd_ready, busy, rsp_valid, rsp_err}, 7'b0111000);
        chk("reset_rdata", rsp_rdata, 16'h0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            issue(vecs[i], 1'b0, 1'b0, vecs[i]);
            capture(vecs[i]);
        end

        // Back-to-back: a read held on cmd_valid behind a write.
        v = vecs[3];
        v.exp_rdata = 16'h0001;
        v.exp_err   = 1'b0;
        issue(v, 1'b0, 1'b1, vecs[1]);
        capture(v);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_phy   = 5'h1E;
        cmd_reg   = 5'h1E;
        capture(vecs[1]);

        // Abort: reset during the high phase of bit 40 of a write.
        issue(vecs[0], 1'b0, 1'b0, vecs[0]);
        rises = 0;
        prev  = 1'b0;
        for (int cyc = 0; cyc < BUDGET && rises < 41; cyc++) begin
            @(negedge clk);
            if (mdc && !prev) rises++;
            prev = mdc;
        end
        chk("abort_reached_bit40", rises, 41);
        reset_n = 1'b0;
        #1;
        chk("abort_outputs", {mdc, mdio_oen, busy, cmd_ready, rsp_valid, mdio_out}, 6'b010101);
        chk("abort_rdata", rsp_rdata, 16'h0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        chk("abort_no_response", seen, 0);
        issue(vecs[1], 1'b0, 1'b0, vecs[1]);
        capture(vecs[1]);

`ifdef MDIO_PRE_SUPPRESS_EN
        // Preamble suppressed: 32-bit read frame starting at ST.
        issue(vecs[2], 1'b1, 1'b0, vecs[2]);
        capture(vecs[2]);
        v = vecs[1];
        issue(v, 1'b1, 1'b0, v);
        capture(v);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
